// File: rtl/hack_pkg.sv
// Shared Hack memory constants used by the RAM hierarchy.
package hack_pkg;
  localparam int HACK_WORD_W  = 16;
  localparam int RAM8_ADDR_W  = 3;
  localparam int RAM64_ADDR_W = 6;
  localparam int NUM_BANKS    = 8;
endpackage

// File: rtl/ram64_gates.sv
// Combinational gate-set primitives: 1-to-8 demux and 8-to-1 word mux.
module dmux8way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic [7:0] out
);
  always_comb begin
    out      = 8'b0;
    out[sel] = in;
  end
endmodule

module mux8way #(
  parameter int WIDTH = 16
) (
  input  logic [7:0][WIDTH-1:0] data,
  input  logic [2:0]            sel,
  output logic [WIDTH-1:0]      out
);
  assign out = data[sel];
endmodule

// File: rtl/ram8.sv
// Eight-word register file: demuxed load, async clear, combinational read.
module ram8
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic [RAM8_ADDR_W-1:0] address,
  output logic [WIDTH-1:0]       out
);
  logic [WIDTH-1:0]       r_word [8];
  logic [7:0]             w_load;
  logic [7:0][WIDTH-1:0]  w_words;

  dmux8way u_load_dmux (
    .in  (load),
    .sel (address),
    .out (w_load)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_word[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (w_load[i]) r_word[i] <= in;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_pack
    assign w_words[gi] = r_word[gi];
  end

  mux8way #(.WIDTH(WIDTH)) u_read_mux (
    .data (w_words),
    .sel  (address),
    .out  (out)
  );
endmodule

// File: rtl/ram64.sv
// 64-word Hack RAM: eight ram8 banks selected by address[5:3].
module ram64
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in,
  input  logic                    load,
  input  logic [RAM64_ADDR_W-1:0] address,
  output logic [WIDTH-1:0]        out
);
  logic [NUM_BANKS-1:0]            w_bank_load;
  logic [NUM_BANKS-1:0][WIDTH-1:0] w_bank_out;

  dmux8way u_bank_dmux (
    .in  (load),
    .sel (address[5:3]),
    .out (w_bank_load)
  );

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    ram8 #(.WIDTH(WIDTH)) u_ram8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (in),
      .load    (w_bank_load[gi]),
      .address (address[2:0]),
      .out     (w_bank_out[gi])
    );
  end

  mux8way #(.WIDTH(WIDTH)) u_bank_mux (
    .data (w_bank_out),
    .sel  (address[5:3]),
    .out  (out)
  );
endmodule

// File: tb/tb_ram64.sv
// Self-checking bench for ram64: directed table, corner sequences, random vs model.
module tb_ram64;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [5:0]  address;
  logic [15:0] out;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] model [64];

  ram64 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load), .address(address), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic read_chk(input string nm, input logic [5:0] a, input logic [15:0] exp);
    address = a;
    #1;
    check($sformatf("%s a=%0d", nm, a), out, exp);
  endtask

  // Writes happen on one posedge; model updated to match the spec's 1-edge latency.
  task automatic do_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; in = d; load = 1'b1;
    @(posedge clk);
    model[a] = d;
    #1;
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in = 16'hFFFF; load = 1'b1; address = 6'd0;
    for (int i = 0; i < 64; i++) model[i] = 16'h0;

    // Reset held across 3 edges with load=1: nothing may be written.
    repeat (3) @(posedge clk);
    #1;
    read_chk("rst_held", 6'd0, 16'h0);
    read_chk("rst_held", 6'd63, 16'h0);
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_chk("rst_rel", 6'd0, 16'h0);
    read_chk("rst_rel", 6'd9, 16'h0);
    read_chk("rst_rel", 6'd63, 16'h0);

    tbl[0] = '{1'b1, 6'd5,  16'h1234, 16'h1234};
    tbl[1] = '{1'b0, 6'd4,  16'h0,    16'h0};
    tbl[2] = '{1'b0, 6'd13, 16'h0,    16'h0};
    tbl[3] = '{1'b0, 6'd37, 16'h0,    16'h0};
    tbl[4] = '{1'b1, 6'd3,  16'hAAAA, 16'hAAAA};
    tbl[5] = '{1'b1, 6'd59, 16'h5555, 16'h5555};
    tbl[6] = '{1'b0, 6'd3,  16'h0,    16'hAAAA};
    tbl[7] = '{1'b0, 6'd11, 16'h0,    16'h0};
    tbl[8] = '{1'b1, 6'd20, 16'h0007, 16'h0007};
    tbl[9] = '{1'b0, 6'd5,  16'h0,    16'h1234};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].we) do_write(tbl[i].addr, tbl[i].din);
      read_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // Read-during-write: old value before the edge, new value right after.
    @(negedge clk);
    address = 6'd20; in = 16'h00F0; load = 1'b1;
    #1; check("rdw_before", out, 16'h0007);
    @(posedge clk); #1;
    check("rdw_after", out, 16'h00F0);
    model[20] = 16'h00F0;
    @(negedge clk);
    load = 1'b0; in = 16'hDEAD;
    @(posedge clk); #1;
    check("rdw_hold", out, 16'h00F0);

    // Full sweep.
    for (int a = 0; a < 64; a++) do_write(6'(a), 16'(a) * 16'h0101);
    for (int a = 0; a < 64; a++) read_chk("sweep", 6'(a), 16'(a) * 16'h0101);

    // Random traffic against the array model, incl. read-during-write.
    for (int n = 0; n < 300; n++) begin
      logic [5:0]  ra;
      logic [15:0] rd;
      logic        rl;
      ra = 6'($urandom_range(0, 63));
      rd = 16'($urandom);
      rl = 1'($urandom_range(0, 1));
      @(negedge clk);
      address = ra; in = rd; load = rl;
      #1; check($sformatf("rnd%0d_pre a=%0d", n, ra), out, model[ra]);
      @(posedge clk);
      if (rl) model[ra] = rd;
      #1; check($sformatf("rnd%0d_post a=%0d", n, ra), out, model[ra]);
    end

    // Async reset between edges with load=1: clears immediately, no write lands.
    @(negedge clk);
    load = 1'b0;
    address = 6'd63;
    for (int a = 0; a < 64; a++) if (model[a] != 16'h0) address = 6'(a);
    @(posedge clk);
    #2;
    check("pre_reset_nonzero", {15'h0, out != 16'h0}, 16'h1);
    in = 16'hBEEF; load = 1'b1;
    rst_n = 1'b0;
    #1; check("async_clear", out, 16'h0);
    @(posedge clk); #1;
    check("reset_wins", out, 16'h0);
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < 64; a++) model[a] = 16'h0;
    for (int a = 0; a < 64; a++) read_chk("post_reset", 6'(a), model[a]);

    // First loaded edge after release performs a normal write.
    do_write(6'd42, 16'hC0DE);
    read_chk("post_rel_write", 6'd42, 16'hC0DE);
    read_chk("post_rel_other", 6'd41, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram64.md
Name: ram64

Overview:
- Hack-compatible 64-word RAM built from registers.
- Downstream of the project-0/1 gate layer: it consumes the and/mux/dmux gates as address decode and read-select.
- Sits below the future RAM512/RAM4K hierarchy, and under the Hack data memory that the CPU addresses.
- Synchronous write on load; combinational read of the addressed word.

Parameters:
- WIDTH, 16, data word width in bits (Hack word = 16).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset; clears every word to 0.
- in  input  WIDTH  write data.
- load  input  1  write enable; when 1, in is written to word[address] at the next rising clk edge.
- address  input  6  word select, 0..63; address[5:3] selects the bank, address[2:0] selects the word within the bank.
- out  output  WIDTH  current contents of word[address] (combinational read).

Behaviour:
- Reset:
  - rst_n=0 immediately clears all 64 words to 0, without waiting for clk.
  - out=0 for any address while reset is held and after release, until the first write.
- Write:
  - On a rising clk edge with rst_n=1 and load=1, word[address] <= in.
  - All other words hold their value.
  - load=0 means no state change.
- Read:
  - out = word[address] at all times, including while load=1.
  - Zero-cycle latency from an address change to out (combinational mux path).
- Read-during-write:
  - In the cycle of a write to word[address], out shows the OLD value.
  - After the edge, out shows the new value.
  - There is no write-through bypass.
- Write latency: 1 edge. The value is visible on out immediately after the clocking edge.
- Address coverage: all 6-bit values are valid, so there is no out-of-range case or wrap handling.
- Simultaneous reset and load: reset wins. No word is written while rst_n=0, whatever the state of load and clk.
- Reset mid-operation: an edge coinciding with rst_n falling is lost. All words read 0 afterwards.
- Reset release: the first edge with rst_n=1 and load=1 performs a normal write.
- No X on out after reset for any address.
- State element: WIDTH-bit register per word, with async clear to 0 and enable = load AND decoded select.

Decomposition:
- Shared package (hack_pkg) contents:
  - localparams HACK_WORD_W=16, RAM8_ADDR_W=3, RAM64_ADDR_W=6.
  - Bank-count constant NUM_BANKS=8.
- Sub-module ram8 (WIDTH parameter): clk, rst_n, in, load, address[2:0], out.
  - Internally: 8 registers, a 1-to-8 load demux, and an 8-to-1 WIDTH-bit read mux.
- ram64 contents:
  - 8 ram8 instances sharing in, clk, rst_n and address[2:0].
  - A 1-to-8 demux of load on address[5:3].
  - An 8-to-1 read mux on address[5:3].
- The demux and mux are reusable combinational gate-level modules from the existing gate set. They are not new blocks.

Test Plan:
- Reset:
  - Drive in=16'hFFFF, load=1, hold rst_n=0 across 3 clk edges, then release.
  - Required: out=0 at address 0, 9, 63; no write occurred.
- Single write/read:
  - Write 16'h1234 to address 5 (load=1 for one edge), then load=0.
  - Required: out=16'h1234 at address 5; out=0 at addresses 4, 13, 37.
- Bank isolation:
  - Write 16'hAAAA to address 3 and 16'h5555 to address 59 (same low bits, banks 0 and 7).
  - Required: address 3 -> 16'hAAAA; address 59 -> 16'h5555; address 11 -> 0.
- Read-during-write:
  - With address 20 holding 16'h0007, set in=16'h00F0, load=1.
  - Required: out=16'h0007 before the edge and out=16'h00F0 immediately after.
  - With load=0 and in=16'hDEAD, required: out stays 16'h00F0 across the next edge.
- Full sweep:
  - Write value = address*16'h0101 to all 64 words, then read back 0..63.
  - Required: every word matches, e.g. address 63 -> 16'h3F3F.
- Async reset mid-operation:
  - After the sweep, pulse rst_n=0 between edges, with load=1 and in=16'hBEEF.
  - Required: out=0 at once, and all 64 words read 0 afterwards.
